// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter in front of a shared mux_4 datapath.
// One requester is granted at a time. The registered grant drives the mux
// select, and the chosen word is offered on a single valid/ready channel.
// Optional feature macro: RR_ARBITER_4_BURST_EN. When it is defined, the
// arbiter adds an i_last port and keeps the grant for a whole burst.

module mux_4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_y
);

    // Plain 4:1 word select
    always_comb begin
        unique case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule

module rr_arbiter_4 #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_req,
    input  logic [W-1:0] i_data0,
    input  logic [W-1:0] i_data1,
    input  logic [W-1:0] i_data2,
    input  logic [W-1:0] i_data3,
    input  logic         i_ready,
`ifdef RR_ARBITER_4_BURST_EN
    input  logic [3:0]   i_last,
`endif
    output logic [3:0]   o_gnt,
    output logic [1:0]   o_sel,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;

    logic [2:0] pickIdle;
    logic [2:0] pickNext;
    logic [1:0] selPlusOne;
    logic       xfer;
    logic       release_w;

    // Returns {found, index} for the first set request bit, scanning
    // upward from the start index and wrapping modulo 4.
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign selPlusOne = sel_q + 2'd1;
    assign pickIdle   = pick(i_req, ptr_q);
    assign pickNext   = pick(i_req, selPlusOne);

    assign o_valid = (state_q == GRANT) & i_req[sel_q];
    assign xfer    = o_valid & i_ready;
    assign o_gnt   = gnt_q;
    assign o_sel   = sel_q;

`ifdef RR_ARBITER_4_BURST_EN
    // A burst keeps the grant until its last word moves or the requester leaves.
    assign release_w = ~i_req[sel_q] | (xfer & i_last[sel_q]);
`else
    // Every transfer, and every withdrawal, gives up the grant.
    assign release_w = ~i_req[sel_q] | xfer;
`endif

    // Next-state, rotate pointer and grant selection
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pickIdle[2]) begin
                    state_d = GRANT;
                    sel_d   = pickIdle[1:0];
                    gnt_d   = 4'b0001 << pickIdle[1:0];
                end else begin
                    sel_d = 2'b00;
                    gnt_d = 4'b0000;
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d = selPlusOne;
                    if (pickNext[2]) begin
                        sel_d = pickNext[1:0];
                        gnt_d = 4'b0001 << pickNext[1:0];
                    end else begin
                        state_d = IDLE;
                        sel_d   = 2'b00;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers; reset drops the grant and restarts priority at 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    mux_4 #(.W(W)) u_mux (
        .i_d0  (i_data0),
        .i_d1  (i_data1),
        .i_d2  (i_data2),
        .i_d3  (i_data3),
        .i_sel (sel_q),
        .o_y   (o_data)
    );

endmodule
